// File: rtl/led_disp_pkg.sv
// -----------------------------------------------------------------------------
// led_disp_pkg
//   Shared constants for the front-panel indicator driver.
//   - One-hot controller state encodings (IDLE .. TEMP).
//   - RGB colour constants, packed as 3-bit {R,G,B}.
//   - blink_div(): clock cycles per half blink period.
// -----------------------------------------------------------------------------
package led_disp_pkg;

  // One-hot states presented by the vending controller
  localparam logic [5:0] ST_IDLE      = 6'h01;
  localparam logic [5:0] ST_GOODS_ONE = 6'h02;
  localparam logic [5:0] ST_GOODS_TWO = 6'h04;
  localparam logic [5:0] ST_PAYMENT   = 6'h08;
  localparam logic [5:0] ST_CHANGE    = 6'h10;
  localparam logic [5:0] ST_TEMP      = 6'h20;

  // Colours as {R,G,B}
  localparam logic [2:0] RGB_OFF    = 3'b000;
  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_GREEN  = 3'b010;
  localparam logic [2:0] RGB_BLUE   = 3'b001;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_WHITE  = 3'b111;

  // Number of clock cycles in one half of a blink period (lit or dark).
  function automatic int blink_div(input int clk_freq_hz, input int blink_hz);
    return clk_freq_hz / (2 * blink_hz);
  endfunction

endpackage

// File: rtl/led_pwm_blink_timer.sv
// -----------------------------------------------------------------------------
// led_pwm_blink_timer
//   Timing base for the indicator driver: blink prescaler, blink phase and the
//   free-running PWM counter with its brightness compare.
//
//   Ports:
//     sys_clk      in   clock, rising edge
//     sys_rst_n    in   synchronous active-low reset
//     restart      in   restart the blink period lit (state change)
//     brightness   in   PWM duty, 0 = off, all-ones = always on
//     blink_phase  out  blink phase that will be held after the coming edge
//     pwm_on       out  PWM gate for the current cycle
// -----------------------------------------------------------------------------
module led_pwm_blink_timer #(
  parameter int BLINK_DIV = 4,
  parameter int PWM_BITS  = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                restart,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                blink_phase,
  output logic                pwm_on
);

  localparam int              PRE_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    prescaler_d   = prescaler_q;
    blink_phase_d = blink_phase_q;
    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
    if (restart) begin
      // A state change wins over the wrap so the new state always opens lit.
      prescaler_d   = '0;
      blink_phase_d = 1'b1;
    end else if (prescaler_q == PRE_LAST) begin
      prescaler_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      prescaler_d   = prescaler_q + PRE_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      prescaler_q   <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
    end else begin
      prescaler_q   <= prescaler_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
    end
  end

  // The output registers sample the phase being loaded this edge, so the LED
  // pattern stays aligned with blink_phase_q: entering a state shows lit on the
  // first registered output and each half period lasts exactly BLINK_DIV cycles.
  assign blink_phase = blink_phase_d;

  // All-ones is forced fully on; otherwise a plain compare gives brightness/2^N.
  assign pwm_on = (&brightness) | (pwm_cnt_q < brightness);

endmodule

// File: rtl/led_status_display.sv
// -----------------------------------------------------------------------------
// led_status_display
//   Front-panel indicator driver for the vending machine. Decodes the one-hot
//   controller state into the button LED bank and two RGB LEDs, with PWM
//   dimming on the RGBs, blinking in CHANGE and an illegal-state fault flag.
//   All outputs are registered (one cycle from the inputs).
//
//   Ports:
//     sys_clk, sys_rst_n          clock / synchronous active-low reset
//     state[5:0]                  one-hot controller state
//     in_goods_high/low[2:0]      goods selection bits
//     in_goods_num[1:0]           quantity
//     money[MONEY_W-1:0]          inserted money
//     brightness[PWM_BITS-1:0]    RGB intensity
//     LED_btn[LED_W-1:0]          button LED bank (not dimmed)
//     RGB1_*                      state colour
//     RGB2_*                      fault indicator (red blinks on illegal state)
// -----------------------------------------------------------------------------
module led_status_display
  import led_disp_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BLINK_HZ    = 2,
  parameter int PWM_BITS    = 4,
  parameter int LED_W       = 16,
  parameter int MONEY_W     = 5
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [5:0]          state,
  input  logic [2:0]          in_goods_high,
  input  logic [2:0]          in_goods_low,
  input  logic [1:0]          in_goods_num,
  input  logic [MONEY_W-1:0]  money,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [LED_W-1:0]    LED_btn,
  output logic                RGB1_Red,
  output logic                RGB1_Green,
  output logic                RGB1_Blue,
  output logic                RGB2_Red,
  output logic                RGB2_Green,
  output logic                RGB2_Blue
);

  localparam int BLINK_DIV = blink_div(CLK_FREQ_HZ, BLINK_HZ);

  logic [5:0]       state_q, state_d;
  logic [LED_W-1:0] led_btn_q, led_btn_d;
  logic [2:0]       rgb1_q, rgb1_d;
  logic [2:0]       rgb2_q, rgb2_d;

  logic             restart;
  logic             legal;
  logic             blink_phase;
  logic             pwm_on;
  logic [2:0]       rgb1_col;

  assign restart = (state != state_q);
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign legal   = (state != 6'h00) && ((state & (state - 6'h01)) == 6'h00);

  led_pwm_blink_timer #(
    .BLINK_DIV (BLINK_DIV),
    .PWM_BITS  (PWM_BITS)
  ) u_timer (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .restart     (restart),
    .brightness  (brightness),
    .blink_phase (blink_phase),
    .pwm_on      (pwm_on)
  );

  always_comb begin
    state_d   = state;
    led_btn_d = '0;
    rgb1_col  = RGB_OFF;
    case (state)
      ST_IDLE: begin
        led_btn_d = '0;
        rgb1_col  = RGB_OFF;
      end
      ST_GOODS_ONE, ST_GOODS_TWO: begin
        led_btn_d = LED_W'({in_goods_num, in_goods_high, in_goods_low});
        rgb1_col  = (state == ST_GOODS_ONE) ? RGB_RED : RGB_GREEN;
      end
      ST_PAYMENT: begin
        // Money in the top bits, remaining lower LEDs lit.
        led_btn_d                      = '1;
        led_btn_d[LED_W-1 -: MONEY_W]  = money;
        rgb1_col                       = RGB_BLUE;
      end
      ST_CHANGE: begin
        led_btn_d = blink_phase ? '1 : '0;
        rgb1_col  = blink_phase ? RGB_YELLOW : RGB_OFF;
      end
      ST_TEMP: begin
        led_btn_d = '1;
        rgb1_col  = RGB_WHITE;
      end
      default: begin
        led_btn_d = '0;
        rgb1_col  = RGB_OFF;
      end
    endcase
    rgb1_d = rgb1_col & {3{pwm_on}};
    rgb2_d = (!legal && blink_phase && pwm_on) ? RGB_RED : RGB_OFF;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= '0;
      led_btn_q <= '0;
      rgb1_q    <= '0;
      rgb2_q    <= '0;
    end else begin
      state_q   <= state_d;
      led_btn_q <= led_btn_d;
      rgb1_q    <= rgb1_d;
      rgb2_q    <= rgb2_d;
    end
  end

  assign LED_btn    = led_btn_q;
  assign RGB1_Red   = rgb1_q[2];
  assign RGB1_Green = rgb1_q[1];
  assign RGB1_Blue  = rgb1_q[0];
  assign RGB2_Red   = rgb2_q[2];
  assign RGB2_Green = rgb2_q[1];
  assign RGB2_Blue  = rgb2_q[0];

endmodule

// File: tb/tb_led_status_display.sv
module tb_led_status_display;

  localparam int CLK_F = 16;
  localparam int BHZ   = 2;
  localparam int DIV   = CLK_F / (2 * BHZ);
  localparam int PB    = 4;
  localparam int LW    = 16;
  localparam int MW    = 5;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [5:0]    state = 6'h00;
  logic [2:0]    in_goods_high = 3'b0;
  logic [2:0]    in_goods_low = 3'b0;
  logic [1:0]    in_goods_num = 2'b0;
  logic [MW-1:0] money = '0;
  logic [PB-1:0] brightness = '0;
  logic [LW-1:0] LED_btn;
  logic RGB1_Red, RGB1_Green, RGB1_Blue, RGB2_Red, RGB2_Green, RGB2_Blue;

  led_status_display #(
    .CLK_FREQ_HZ (CLK_F),
    .BLINK_HZ    (BHZ),
    .PWM_BITS    (PB),
    .LED_W       (LW),
    .MONEY_W     (MW)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .state         (state),
    .in_goods_high (in_goods_high),
    .in_goods_low  (in_goods_low),
    .in_goods_num  (in_goods_num),
    .money         (money),
    .brightness    (brightness),
    .LED_btn       (LED_btn),
    .RGB1_Red      (RGB1_Red),
    .RGB1_Green    (RGB1_Green),
    .RGB1_Blue     (RGB1_Blue),
    .RGB2_Red      (RGB2_Red),
    .RGB2_Green    (RGB2_Green),
    .RGB2_Blue     (RGB2_Blue)
  );

  always #5 sys_clk = ~sys_clk;

  // Scoreboard: {LED_btn, RGB1 RGB, RGB2 RGB}
  logic [21:0] exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   running  = 0;
  bit   done     = 0;

  // Reference model: time since last blink restart / since reset
  int         t_since = 0;
  int         k_since = 0;
  bit         base_phase = 0;
  logic [5:0] prev_state = 6'h00;

  task automatic drive(input logic rst_n, input logic [5:0] st, input logic [2:0] hi,
                       input logic [2:0] lo, input logic [1:0] num,
                       input logic [MW-1:0] m, input logic [PB-1:0] br);
    logic [15:0] e_led;
    logic [2:0]  e1, e2;
    bit          ph, pw, lg;
    @(negedge sys_clk);
    sys_rst_n = rst_n; state = st; in_goods_high = hi; in_goods_low = lo;
    in_goods_num = num; money = m; brightness = br;
    e_led = 16'h0; e1 = 3'b0; e2 = 3'b0;
    if (!rst_n) begin
      t_since = 0; k_since = 0; base_phase = 0; prev_state = 6'h00;
    end else begin
      if (st != prev_state) begin
        t_since = 0; base_phase = 1;
      end else begin
        t_since++;
      end
      prev_state = st;
      k_since++;
      // Blink: lit/dark halves of DIV cycles each, starting from base_phase.
      ph = base_phase ^ (((t_since / DIV) % 2) == 1);
      pw = (br == 4'hF) || (((k_since - 1) % 16) < int'(br));
      lg = ($countones(st) == 1);
      case (st)
        6'h02: begin e_led = {8'h00, num, hi, lo}; e1 = 3'b100; end
        6'h04: begin e_led = {8'h00, num, hi, lo}; e1 = 3'b010; end
        6'h08: begin e_led = {m, 11'h7FF}; e1 = 3'b001; end
        6'h10: begin e_led = ph ? 16'hFFFF : 16'h0000; e1 = ph ? 3'b110 : 3'b000; end
        6'h20: begin e_led = 16'hFFFF; e1 = 3'b111; end
        default: begin e_led = 16'h0000; e1 = 3'b000; end
      endcase
      if (!pw) e1 = 3'b000;
      if (!lg && ph && pw) e2 = 3'b100;
    end
    exp_q.push_back({e_led, e1, e2});
    running = 1;
  endtask

  task automatic hold(input int n, input logic [5:0] st, input logic [2:0] hi,
                      input logic [2:0] lo, input logic [1:0] num,
                      input logic [MW-1:0] m, input logic [PB-1:0] br);
    for (int i = 0; i < n; i++) drive(1'b1, st, hi, lo, num, m, br);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion within 500000 time units");
    $fatal(1, "timeout");
  end

  initial begin : main
    fork
      begin : driver
        logic [5:0] st;
        int         len;
        int         r;
        logic [PB-1:0] br;
        // Reset held with CHANGE present
        for (int i = 0; i < 3; i++) drive(1'b0, 6'h10, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        hold(10, 6'h10, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        // GOODS_one -> 00EA, red steady
        hold(6, 6'h02, 3'b101, 3'b010, 2'b11, 5'd0, 4'hF);
        hold(3, 6'h04, 3'b011, 3'b100, 2'b01, 5'd0, 4'hF);
        // PAYMENT -> B7FF, then PWM duty checks
        hold(4, 6'h08, 3'b0, 3'b0, 2'b0, 5'b10110, 4'hF);
        hold(32, 6'h08, 3'b0, 3'b0, 2'b0, 5'b10110, 4'd4);
        hold(16, 6'h08, 3'b0, 3'b0, 2'b0, 5'b10110, 4'd0);
        // CHANGE blink, TEMP, re-enter CHANGE mid-phase
        hold(21, 6'h10, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        hold(3, 6'h20, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        hold(10, 6'h10, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        // Illegal state, then IDLE
        hold(12, 6'h06, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        hold(3, 6'h01, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        hold(9, 6'h00, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        // Reset mid-blink
        hold(5, 6'h10, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        drive(1'b0, 6'h10, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        hold(9, 6'h10, 3'b0, 3'b0, 2'b0, 5'd0, 4'hF);
        // Randomised traffic
        st = 6'h01;
        br = 4'hF;
        for (int blk = 0; blk < 200; blk++) begin
          r = $urandom_range(0, 9);
          if (r <= 5)      st = 6'h01 << r;
          else if (r == 6) st = 6'h00;
          else if (r == 7) st = 6'($urandom);
          len = $urandom_range(1, 12);
          for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 7) == 0) br = PB'($urandom);
            drive(($urandom_range(0, 199) != 0), st, 3'($urandom), 3'($urandom),
                  2'($urandom), MW'($urandom), br);
          end
        end
        done = 1;
      end
      begin : monitor
        logic [21:0] got, exp;
        wait (running);
        forever begin
          @(posedge sys_clk);
          #1;
          got = {LED_btn, RGB1_Red, RGB1_Green, RGB1_Blue, RGB2_Red, RGB2_Green, RGB2_Blue};
          if (exp_q.size() == 0) begin
            if (done) break;
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: output %h present, no expected entry queued", got);
          end else begin
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
              n_fail++;
              $display("FAIL outputs t=%0t: got LED=%h RGB1=%b RGB2=%b, expected LED=%h RGB1=%b RGB2=%b",
                       $time, got[21:6], got[5:3], got[2:0], exp[21:6], exp[5:3], exp[2:0]);
            end
          end
        end
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_status_display.md
Name: led_status_display

Overview:
Parametrised next-generation front-panel indicator driver for the vending machine. It takes the one-hot controller state, the goods selection, the inserted money and a brightness setting. It drives the button LED bank and two RGB LEDs. Compared with the current driver it adds PWM dimming, blinking in the CHANGE state, a configurable LED bank width and a second RGB LED that flags an illegal-state fault. It sits between the vending FSM and the board LED pins.

Parameters:
CLK_FREQ_HZ, 100000000, sys_clk frequency.
BLINK_HZ, 2, full blink period rate; BLINK_DIV = CLK_FREQ_HZ/(2*BLINK_HZ), must be >= 2.
PWM_BITS, 4, brightness and PWM counter width.
LED_W, 16, number of button LEDs; must be >= 8 and >= MONEY_W.
MONEY_W, 5, money input width.

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge.
sys_rst_n  in  1  reset, synchronous, active-low.
state  in  6  one-hot FSM state: IDLE=01h, GOODS_one=02h, GOODS_two=04h, PAYMENT=08h, CHANGE=10h, TEMP=20h.
in_goods_high  in  3  selected high-price goods bits.
in_goods_low  in  3  selected low-price goods bits.
in_goods_num  in  2  quantity selection.
money  in  MONEY_W  inserted money.
brightness  in  PWM_BITS  RGB intensity; 0 = off, all-ones = constant on.
LED_btn  out  LED_W  button LED bank.
RGB1_Red, RGB1_Green, RGB1_Blue  out  1 each  state colour.
RGB2_Red, RGB2_Green, RGB2_Blue  out  1 each  fault indicator.

Behaviour:
- Reset: a synchronous reset with sys_rst_n=0 at a clock edge clears every register.
  - All outputs are 0, prescaler = 0, blink_phase = 0, pwm_cnt = 0, state_q = 0.
  - Reset asserted mid-operation (including mid-blink) takes effect at the next edge.
- All inputs are assumed synchronous to sys_clk. All outputs are registered with 1 cycle of latency from inputs.
- state_q registers state. A state change is detected as state != state_q.
  - On a state change, the prescaler is cleared and blink_phase is set to 1, so the next blink period begins lit.
- Prescaler counts 0..BLINK_DIV-1.
  - At BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - A state change in the same cycle takes priority over the wrap.
- pwm_cnt is free-running over PWM_BITS and wraps at all-ones.
  - pwm_on = 1 when brightness is all-ones, else (pwm_cnt < brightness).
- legal = state has exactly one bit set.
- LED_btn next value by state:
  - IDLE: all 0.
  - GOODS_one or GOODS_two: {zeros, in_goods_num, in_goods_high, in_goods_low}, zero-extended to LED_W.
  - PAYMENT: {money, (LED_W-MONEY_W) ones}.
  - CHANGE: all ones when blink_phase=1, all 0 otherwise.
  - TEMP: all ones, steady.
  - Illegal state: all 0.
  - LED_btn is not PWM-gated.
- RGB1 colour (R,G,B) by state; each bit is ANDed with pwm_on:
  - IDLE (0,0,0).
  - GOODS_one red (1,0,0).
  - GOODS_two green (0,1,0).
  - PAYMENT blue (0,0,1).
  - CHANGE yellow (1,1,0), additionally ANDed with blink_phase.
  - TEMP white (1,1,1).
  - Illegal (0,0,0).
- RGB2:
  - Illegal state (zero or more than one bit set): red = blink_phase AND pwm_on; green and blue = 0.
  - Legal state: all 0.
- Simultaneous events: brightness changes take effect on the next PWM compare with no counter restart. Input changes during a blink affect only the LED_btn pattern, not the blink phase.

Decomposition:
- Package led_disp_pkg holds:
  - State localparams (IDLE..TEMP).
  - RGB colour constants (OFF, RED, GREEN, BLUE, YELLOW, WHITE) as 3-bit {R,G,B}.
  - The BLINK_DIV derivation function.
- One sub-module, led_pwm_blink_timer, owns the prescaler, blink_phase, pwm_cnt and pwm_on generation.
  - Its inputs are sys_clk, sys_rst_n, restart and brightness.
  - Its outputs are blink_phase and pwm_on.
- The top level does decode and output registers.

Test Plan:
Bench parameters: CLK_FREQ_HZ=16, BLINK_HZ=2 (BLINK_DIV=4), PWM_BITS=4, LED_W=16, MONEY_W=5.
1. Reset: hold sys_rst_n=0 with state=10h for 3 cycles -> LED_btn=0000h and all RGB outputs 0; release -> first non-zero output one cycle later.
2. GOODS_one, high=3'b101, low=3'b010, num=2'b11, brightness=Fh -> LED_btn=00EAh, RGB1=(1,0,0) steady.
3. PAYMENT, money=5'b10110 -> LED_btn=B7FFh.
4. PAYMENT, brightness=4 -> RGB1_Blue high exactly 4 of every 16 cycles; brightness=0 -> always low.
5. Enter CHANGE with brightness=Fh -> LED_btn=FFFFh and RGB1=(1,1,0) for 4 cycles, then 0 for 4 cycles, repeating. Re-enter CHANGE from TEMP mid-phase -> restarts lit.
6. state=06h (illegal) -> LED_btn=0, RGB1 off, RGB2_Red toggles every 4 cycles. state=01h -> RGB2 off after 1 cycle.
